// File: rtl/ocx_tlx_rcv_err_log_if.sv
// Signal bundle between the TLX parser error-detection stage, firmware
// readout and the receive-side error logger.
// master: the side that produces error records and read requests.
// slave : the error logger itself.
interface ocx_tlx_rcv_err_log_if #(
  parameter int CNT_WIDTH = 16
);
  // error record ingest
  logic [31:0]          rcv_xmt_debug_info;
  logic                 rcv_xmt_debug_valid;
  logic                 rcv_xmt_debug_fatal;
  // control
  logic                 err_clr;
  // readout port
  logic                 log_rd_req;
  logic                 log_rd_ack;
  logic [31:0]          log_rd_data;
  logic                 log_rd_empty;
  // status
  logic                 log_overflow;
  logic [CNT_WIDTH-1:0] log_count;
  logic                 first_err_valid;
  logic [31:0]          first_err_info;
  logic [15:0]          first_err_timestamp;
  logic [15:0]          err_type_seen;
  logic                 tlx_fatal_int;

  modport master (
    output rcv_xmt_debug_info, rcv_xmt_debug_valid, rcv_xmt_debug_fatal,
           err_clr, log_rd_req,
    input  log_rd_ack, log_rd_data, log_rd_empty, log_overflow, log_count,
           first_err_valid, first_err_info, first_err_timestamp,
           err_type_seen, tlx_fatal_int
  );

  modport slave (
    input  rcv_xmt_debug_info, rcv_xmt_debug_valid, rcv_xmt_debug_fatal,
           err_clr, log_rd_req,
    output log_rd_ack, log_rd_data, log_rd_empty, log_overflow, log_count,
           first_err_valid, first_err_info, first_err_timestamp,
           err_type_seen, tlx_fatal_int
  );
endinterface

// File: rtl/ocx_tlx_rcv_err_log.sv
// Receive-side error logger for the TLX parser.
// Captures the first error, keeps a saturating error count and a sticky
// per-code seen mask, buffers records in a DEPTH-entry FIFO for firmware
// readout (req/ack, one-cycle response) and raises a sticky fatal flag.
// err_clr wipes all logged state; a record arriving with err_clr is applied
// on top of the cleared state.
// Optional build macro OCX_TLX_ERR_TIMESTAMP_EN adds a free-running 16-bit
// cycle counter whose value is stamped into first_err_timestamp; without it
// first_err_timestamp is tied to zero.
module ocx_tlx_rcv_err_log #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   tlx_clk,
  input  logic                   reset_n,
  ocx_tlx_rcv_err_log_if.slave   bus
);

  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  // FIFO storage and bookkeeping
  logic [31:0]          fifo_mem [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          occ_q;

  // ingest/readout decode
  logic                 rec_valid;
  logic                 clr;
  logic [15:0]          code_onehot;
  logic                 eff_empty;
  logic                 eff_full;
  logic                 do_pop;
  logic                 do_push;
  logic [AW-1:0]        wr_ptr_base, rd_ptr_base;
  logic [AW:0]          occ_base;
  logic [AW-1:0]        wr_addr;

  // status registers and their next values
  logic [CNT_WIDTH-1:0] count_q, count_base, count_d;
  logic [15:0]          seen_q, seen_d;
  logic                 first_valid_q, first_valid_base, first_valid_d;
  logic [31:0]          first_info_q, first_info_d;
  logic                 first_load;
  logic                 fatal_q, fatal_d;
  logic                 ovf_q, ovf_d;

  // readout response registers
  logic                 rd_ack_q;
  logic [31:0]          rd_data_q;
  logic                 rd_empty_q;

  assign rec_valid = bus.rcv_xmt_debug_valid;
  assign clr       = bus.err_clr;

  // FIFO control: a clear makes the FIFO look empty this cycle so a
  // coincident read returns empty and a coincident record lands in slot 0.
  always_comb begin
    code_onehot = 16'd1 << bus.rcv_xmt_debug_info[3:0];
    wr_ptr_base = clr ? '0 : wr_ptr_q;
    rd_ptr_base = clr ? '0 : rd_ptr_q;
    occ_base    = clr ? '0 : occ_q;
    eff_empty   = (occ_base == '0);
    eff_full    = (occ_base == OCC_FULL);
    // An empty FIFO never bypasses: a push and pop to an empty FIFO give an
    // empty response and the record stays.
    do_pop      = bus.log_rd_req && !eff_empty;
    // When full, a same-cycle pop frees the slot the push will use.
    do_push     = rec_valid && (!eff_full || do_pop);
    wr_addr     = wr_ptr_base;
  end

  // FIFO pointer and occupancy update; pointers wrap naturally (power of two)
  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_base + AW'(do_push);
      rd_ptr_q <= rd_ptr_base + AW'(do_pop);
      occ_q    <= occ_base + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // FIFO storage write; contents are only observable through a valid pop
  always_ff @(posedge tlx_clk) begin
    if (do_push) begin
      fifo_mem[wr_addr] <= bus.rcv_xmt_debug_info;
    end
  end

  // Next-state for the logged status, with the clear applied before the
  // coincident record so that record becomes the first one logged.
  always_comb begin
    count_base       = clr ? '0 : count_q;
    first_valid_base = clr ? 1'b0 : first_valid_q;

    count_d = count_base;
    if (rec_valid && !(&count_base)) begin
      count_d = count_base + CNT_WIDTH'(1);
    end

    seen_d = (clr ? 16'h0000 : seen_q) | (rec_valid ? code_onehot : 16'h0000);

    first_load    = rec_valid && !first_valid_base;
    first_valid_d = first_valid_base || rec_valid;
    first_info_d  = clr ? 32'h0 : first_info_q;
    if (first_load) begin
      first_info_d = bus.rcv_xmt_debug_info;
    end

    fatal_d = (clr ? 1'b0 : fatal_q) | (rec_valid && bus.rcv_xmt_debug_fatal);

    // Dropped record: push request that found the FIFO full with no pop.
    ovf_d = (clr ? 1'b0 : ovf_q) | (rec_valid && !do_push);
  end

  // Logged status registers
  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q       <= '0;
      seen_q        <= '0;
      first_valid_q <= 1'b0;
      first_info_q  <= '0;
      fatal_q       <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      count_q       <= count_d;
      seen_q        <= seen_d;
      first_valid_q <= first_valid_d;
      first_info_q  <= first_info_d;
      fatal_q       <= fatal_d;
      ovf_q         <= ovf_d;
    end
  end

  // Readout response: one-cycle ack, data held between acks
  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ack_q   <= 1'b0;
      rd_data_q  <= '0;
      rd_empty_q <= 1'b0;
    end else begin
      rd_ack_q   <= bus.log_rd_req;
      rd_empty_q <= bus.log_rd_req && !do_pop;
      if (bus.log_rd_req) begin
        rd_data_q <= do_pop ? fifo_mem[rd_ptr_base] : 32'h0;
      end
    end
  end

`ifdef OCX_TLX_ERR_TIMESTAMP_EN
  logic [15:0] ts_cnt_q;
  logic [15:0] first_ts_q;

  // Free-running cycle counter; err_clr deliberately leaves it running
  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 16'd1;
    end
  end

  // Stamp of the first error; a load coincident with a clear wins
  always_ff @(posedge tlx_clk or negedge reset_n) begin
    if (!reset_n) begin
      first_ts_q <= '0;
    end else if (first_load) begin
      first_ts_q <= ts_cnt_q;
    end else if (clr) begin
      first_ts_q <= '0;
    end
  end

  assign bus.first_err_timestamp = first_ts_q;
`else
  assign bus.first_err_timestamp = 16'h0000;
`endif

  assign bus.log_rd_ack      = rd_ack_q;
  assign bus.log_rd_data     = rd_data_q;
  assign bus.log_rd_empty    = rd_empty_q;
  assign bus.log_overflow    = ovf_q;
  assign bus.log_count       = count_q;
  assign bus.first_err_valid = first_valid_q;
  assign bus.first_err_info  = first_info_q;
  assign bus.err_type_seen   = seen_q;
  assign bus.tlx_fatal_int   = fatal_q;

endmodule

// File: tb/tb_ocx_tlx_rcv_err_log.sv
// Self-checking bench for ocx_tlx_rcv_err_log (DEPTH=4, CNT_WIDTH=16).
// Read responses are predicted from a queue model of the FIFO when the
// request is driven and compared when the ack appears.
module tb_ocx_tlx_rcv_err_log;

  logic tlx_clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 tlx_clk = ~tlx_clk;

  ocx_tlx_rcv_err_log_if #(.CNT_WIDTH(16)) bus ();

  ocx_tlx_rcv_err_log #(.DEPTH(4), .CNT_WIDTH(16)) dut (
    .tlx_clk (tlx_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] mdl_fifo[$];
  logic [32:0] exp_q[$];

  task automatic step();
    @(posedge tlx_clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.rcv_xmt_debug_info  = 32'h0;
    bus.rcv_xmt_debug_valid = 1'b0;
    bus.rcv_xmt_debug_fatal = 1'b0;
    bus.err_clr             = 1'b0;
    bus.log_rd_req          = 1'b0;
  endtask

  task automatic apply_reset();
    drive_idle();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    mdl_fifo.delete();
    exp_q.delete();
  endtask

  // One clock of stimulus; the model applies clear, then pop, then push.
  task automatic cyc(input logic vld, input logic [31:0] info, input logic fatal,
                     input logic req, input logic clr, input string name);
    logic [32:0] got, exp;
    bus.rcv_xmt_debug_valid = vld;
    bus.rcv_xmt_debug_info  = info;
    bus.rcv_xmt_debug_fatal = fatal;
    bus.log_rd_req          = req;
    bus.err_clr             = clr;
    if (clr) mdl_fifo.delete();
    if (req) begin
      if (mdl_fifo.size() > 0) exp_q.push_back({1'b0, mdl_fifo.pop_front()});
      else                     exp_q.push_back({1'b1, 32'h0});
    end
    if (vld && mdl_fifo.size() < 4) mdl_fifo.push_back(info);
    step();
    drive_idle();
    if (req) begin
      n_chk++;
      if (bus.log_rd_ack !== 1'b1) begin
        n_fail++;
        $display("FAIL %s ack: got %b want 1", name, bus.log_rd_ack);
      end
      exp = exp_q.pop_front();
      got = {bus.log_rd_empty, bus.log_rd_data};
      n_chk++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s rd: got empty=%b data=%h want empty=%b data=%h",
                 name, got[32], got[31:0], exp[32], exp[31:0]);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if ({bus.log_rd_ack, bus.log_rd_empty, bus.log_overflow, bus.first_err_valid,
         bus.tlx_fatal_int} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000", {bus.log_rd_ack, bus.log_rd_empty,
               bus.log_overflow, bus.first_err_valid, bus.tlx_fatal_int});
    end
    n_chk++;
    if ({bus.log_count, bus.err_type_seen, bus.first_err_info, bus.log_rd_data,
         bus.first_err_timestamp} !== '0) begin
      n_fail++;
      $display("FAIL reset_words: cnt=%h seen=%h info=%h data=%h ts=%h want all 0",
               bus.log_count, bus.err_type_seen, bus.first_err_info, bus.log_rd_data,
               bus.first_err_timestamp);
    end
  endtask

  task automatic test_single();
    apply_reset();
    cyc(1'b1, 32'h0000_A5C2, 1'b1, 1'b0, 1'b0, "single_push");
    n_chk++;
    if (bus.log_count !== 16'd1) begin
      n_fail++; $display("FAIL single_count: got %h want 0001", bus.log_count);
    end
    n_chk++;
    if (bus.first_err_valid !== 1'b1 || bus.first_err_info !== 32'h0000_A5C2) begin
      n_fail++;
      $display("FAIL single_first: got v=%b info=%h want v=1 info=0000a5c2",
               bus.first_err_valid, bus.first_err_info);
    end
    n_chk++;
    if (bus.err_type_seen !== 16'h0004) begin
      n_fail++; $display("FAIL single_seen: got %h want 0004", bus.err_type_seen);
    end
    n_chk++;
    if (bus.tlx_fatal_int !== 1'b1) begin
      n_fail++; $display("FAIL single_fatal: got %b want 1", bus.tlx_fatal_int);
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "single_rd1");
    step();
    n_chk++;
    if (bus.log_rd_ack !== 1'b0 || bus.log_rd_data !== 32'h0000_A5C2) begin
      n_fail++;
      $display("FAIL single_hold: got ack=%b data=%h want ack=0 data=0000a5c2",
               bus.log_rd_ack, bus.log_rd_data);
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "single_rd2");
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 1; i <= 5; i++) cyc(1'b1, 32'h100 | i, 1'b0, 1'b0, 1'b0, "ovf_push");
    n_chk++;
    if (bus.log_overflow !== 1'b1 || bus.log_count !== 16'd5) begin
      n_fail++;
      $display("FAIL ovf_status: got ovf=%b cnt=%h want ovf=1 cnt=0005",
               bus.log_overflow, bus.log_count);
    end
    n_chk++;
    if (bus.err_type_seen !== 16'h003E || bus.tlx_fatal_int !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_seen: got seen=%h fatal=%b want seen=003e fatal=0",
               bus.err_type_seen, bus.tlx_fatal_int);
    end
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "ovf_rd");
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    for (int i = 1; i <= 4; i++) cyc(1'b1, 32'h200 | i, 1'b0, 1'b0, 1'b0, "fpp_fill");
    cyc(1'b1, 32'h0000_0209, 1'b0, 1'b1, 1'b0, "fpp_both");
    n_chk++;
    if (bus.log_overflow !== 1'b0) begin
      n_fail++; $display("FAIL fpp_ovf: got %b want 0", bus.log_overflow);
    end
  endtask

  // Drains the four records left by test_full_push_pop plus one empty,
  // with the request held high: one response per cycle.
  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "b2b_rd");
  endtask

  task automatic test_empty_push_pop();
    apply_reset();
    cyc(1'b1, 32'h0000_0335, 1'b0, 1'b1, 1'b0, "epp_both");
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "epp_rd");
  endtask

  task automatic test_clear();
    apply_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h4A0 | i, 1'b1, 1'b0, 1'b0, "clr_fill");
    cyc(1'b1, 32'h0000_0017, 1'b0, 1'b1, 1'b1, "clr_both");
    n_chk++;
    if (bus.log_count !== 16'd1 || bus.first_err_info !== 32'h0000_0017 ||
        bus.first_err_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_first: got cnt=%h info=%h v=%b want cnt=0001 info=00000017 v=1",
               bus.log_count, bus.first_err_info, bus.first_err_valid);
    end
    n_chk++;
    if (bus.err_type_seen !== 16'h0080 || bus.tlx_fatal_int !== 1'b0 ||
        bus.log_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_status: got seen=%h fatal=%b ovf=%b want seen=0080 fatal=0 ovf=0",
               bus.err_type_seen, bus.tlx_fatal_int, bus.log_overflow);
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "clr_rd1");
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "clr_rd2");
  endtask

  task automatic test_saturate();
    apply_reset();
    bus.rcv_xmt_debug_valid = 1'b1;
    bus.rcv_xmt_debug_info  = 32'h0000_0003;
    repeat (65534) step();
    n_chk++;
    if (bus.log_count !== 16'hFFFE) begin
      n_fail++; $display("FAIL sat_fffe: got %h want fffe", bus.log_count);
    end
    step();
    n_chk++;
    if (bus.log_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_ffff: got %h want ffff", bus.log_count);
    end
    step();
    drive_idle();
    n_chk++;
    if (bus.log_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL sat_hold: got %h want ffff", bus.log_count);
    end
  endtask

  task automatic test_timestamp();
    apply_reset();
    repeat (100) step();
    cyc(1'b1, 32'h0000_0051, 1'b0, 1'b0, 1'b0, "ts_first");
`ifdef OCX_TLX_ERR_TIMESTAMP_EN
    n_chk++;
    if (bus.first_err_timestamp !== 16'd100) begin
      n_fail++; $display("FAIL ts_first: got %0d want 100", bus.first_err_timestamp);
    end
    repeat (7) step();
    cyc(1'b1, 32'h0000_0052, 1'b0, 1'b0, 1'b0, "ts_second");
    n_chk++;
    if (bus.first_err_timestamp !== 16'd100) begin
      n_fail++; $display("FAIL ts_second: got %0d want 100", bus.first_err_timestamp);
    end
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "ts_clr");
    n_chk++;
    if (bus.first_err_timestamp !== 16'd0) begin
      n_fail++; $display("FAIL ts_clr: got %0d want 0", bus.first_err_timestamp);
    end
`else
    n_chk++;
    if (bus.first_err_timestamp !== 16'd0) begin
      n_fail++; $display("FAIL ts_tied: got %0d want 0", bus.first_err_timestamp);
    end
`endif
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cyc(1'b1, 32'h0000_0666, 1'b1, 1'b0, 1'b0, "mid_push");
    bus.log_rd_req = 1'b1;
    step();
    bus.log_rd_req = 1'b0;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (bus.log_rd_ack !== 1'b0 || bus.log_count !== 16'd0 || bus.tlx_fatal_int !== 1'b0 ||
        bus.log_rd_data !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset: got ack=%b cnt=%h fatal=%b data=%h want all 0",
               bus.log_rd_ack, bus.log_count, bus.tlx_fatal_int, bus.log_rd_data);
    end
    apply_reset();
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, "mid_rd_empty");
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_empty_push_pop();
    test_clear();
    test_timestamp();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ocx_tlx_rcv_err_log.md
Name: ocx_tlx_rcv_err_log

Overview:
- Receive-side error logger. Sits directly downstream of the TLX parser error-detection stage and consumes its rcv_xmt_debug_info/valid/fatal outputs.
- Captures the first error, counts all errors and tracks which error codes have been seen.
- Buffers error records in a small FIFO for firmware readout through a request/acknowledge port.
- Raises a sticky fatal indication toward the TLX interrupt/status logic.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_WIDTH, 16, error counter width; counter saturates.

Ports:
- tlx_clk  input  1  clock
- reset_n  input  1  asynchronous active-low reset
- rcv_xmt_debug_info  input  32  error record; [3:0] error code, [31:4] context
- rcv_xmt_debug_valid  input  1  error record valid, single-cycle
- rcv_xmt_debug_fatal  input  1  record is fatal; qualified by valid
- err_clr  input  1  pulse; clears all logged state
- log_rd_req  input  1  pulse; request pop of oldest record
- log_rd_ack  output  1  one-cycle response to log_rd_req
- log_rd_data  output  32  popped record; 0 when the response is empty
- log_rd_empty  output  1  qualifies log_rd_ack; 1 means no record was available
- log_overflow  output  1  sticky; a record was dropped because the FIFO was full
- log_count  output  CNT_WIDTH  saturating total error count
- first_err_valid  output  1  sticky; first_err_info is valid
- first_err_info  output  32  first record since reset/clear
- first_err_timestamp  output  16  cycle stamp of the first error (optional feature)
- err_type_seen  output  16  sticky; bit[n] set when code n has been logged
- tlx_fatal_int  output  1  sticky fatal indication

Behaviour:
- Reset (async assert, sync deassert use):
  - All outputs 0 and the FIFO empty.
  - Read/write pointers and the occupancy counter cleared.
- Ingest, when valid=1:
  - Record is written to the FIFO at the tail.
  - log_count increments, unless it is all-ones (saturate, no wrap).
  - err_type_seen[info[3:0]] is set.
  - If first_err_valid=0, first_err_info is loaded and first_err_valid is set.
  - If fatal=1, tlx_fatal_int is set.
  - All updates are visible the cycle after valid.
- FIFO:
  - Occupancy counter runs 0..DEPTH, with binary wrap-around pointers.
  - Full with push and no pop: record dropped, log_overflow set. log_count and err_type_seen still update; the count reflects every detected error.
  - Full with push and pop in the same cycle: both occur, no overflow, occupancy unchanged.
  - Empty with push and pop in the same cycle: the pop returns an empty response. The pushed record is retained; there is no bypass.
- Readout:
  - log_rd_req sampled at cycle N gives log_rd_ack=1 at N+1 for exactly one cycle.
  - If non-empty at N: log_rd_data is the head record, log_rd_empty=0, head popped.
  - If empty at N: log_rd_data=0, log_rd_empty=1.
  - Back-to-back requests on consecutive cycles are each serviced: one pop per cycle, no bubble.
  - log_rd_data holds its last value when log_rd_ack=0.
- Clear (err_clr=1 at cycle N):
  - At N+1: FIFO flushed; log_count, err_type_seen, first_err_valid/info, log_overflow and tlx_fatal_int all 0.
  - A valid record coincident with err_clr is applied after the clear. It becomes the first error, log_count=1, it sits alone in the FIFO, and its type bit and fatal bit are set.
  - A log_rd_req coincident with err_clr returns an empty response at N+1.
- Reset mid-operation: all state returns to reset values immediately; any pending rd_ack is cancelled.
- Latency: input to log/status is 1 cycle; read request to ack is 1 cycle.

Optional Feature:
- Macro OCX_TLX_ERR_TIMESTAMP_EN.
- Defined:
  - A 16-bit free-running cycle counter is added, reset to 0, wrapping from 0xFFFF to 0x0000.
  - Its current value is captured into first_err_timestamp when first_err_info loads.
  - err_clr zeroes first_err_timestamp but does not reset the free-running counter.
- Not defined: no counter logic is built; first_err_timestamp is tied to 0. The port exists in both builds.

Test Plan:
- Reset, then a single valid with info=0x0000_A5C2, fatal=1 -> next cycle: log_count=1, first_err_valid=1, first_err_info=0x0000A5C2, err_type_seen=0x0004, tlx_fatal_int=1. Then a rd_req -> ack with data 0x0000A5C2, empty=0; a second rd_req -> ack with empty=1, data=0.
- Five non-fatal records with codes 1..5, DEPTH=4 -> log_overflow=1, log_count=5, err_type_seen=0x003E. Four reads return codes 1..4 in order; the fifth read reports empty.
- FIFO full, a push and a rd_req in the same cycle -> no overflow, occupancy stays 4, the popped record is the oldest.
- err_clr coincident with valid info=0x0000_0017 -> next cycle: log_count=1, first_err_info=0x00000017, err_type_seen=0x0080, FIFO holds 1 entry, tlx_fatal_int=0.
- Force log_count to 0xFFFF with CNT_WIDTH=16, then one more valid -> log_count stays 0xFFFF.
- With OCX_TLX_ERR_TIMESTAMP_EN, reset deasserted, first valid 100 cycles later -> first_err_timestamp=100 (±0 against the bench counter); a second error leaves it unchanged.
